// File: rtl/morra_match_sequencer_if.sv
// Player/resolver bus for the morra cinese match sequencer.
// master: player input logic + round resolver; slave: the sequencer.
interface morra_match_sequencer_if;
  logic       INIZIA;
  logic [1:0] PRIMO;
  logic [1:0] SECONDO;
  logic       MOSSA_VALIDA;
  logic       MOSSA_PRONTA;
  logic       RIS_REQ;
  logic [1:0] RIS_A;
  logic [1:0] RIS_B;
  logic       RIS_ACK;
  logic [1:0] RIS_ESITO;
  logic [1:0] MANCHE;
  logic [1:0] PARTITA;

  modport master (
    output INIZIA, PRIMO, SECONDO, MOSSA_VALIDA, RIS_ACK, RIS_ESITO,
    input  MOSSA_PRONTA, RIS_REQ, RIS_A, RIS_B, MANCHE, PARTITA
  );

  modport slave (
    input  INIZIA, PRIMO, SECONDO, MOSSA_VALIDA, RIS_ACK, RIS_ESITO,
    output MOSSA_PRONTA, RIS_REQ, RIS_A, RIS_B, MANCHE, PARTITA
  );
endinterface

// File: rtl/morra_match_sequencer.sv
// Match-level controller for morra cinese: configures match length, accepts
// move pairs, enforces the winning-move lock, drives the round resolver via
// REQ/ACK, keeps scores and declares the match result.
// Optional per-player match-win statistics: define MORRA_STATS_EN.
module morra_match_sequencer #(
  parameter int MIN_MANCHE = 4,
  parameter int LEAD       = 2,
  parameter int CNT_W      = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  morra_match_sequencer_if.slave bus
`ifdef MORRA_STATS_EN
  ,
  output logic [CNT_W-1:0]      PARTITE_P1,
  output logic [CNT_W-1:0]      PARTITE_P2
`endif
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ATTESA   = 3'd1,
    RISOLVI  = 3'd2,
    AGGIORNA = 3'd3,
    FINE     = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] max_manche_q, max_manche_d;
  logic [CNT_W-1:0] rounds_q, rounds_d;
  logic [CNT_W-1:0] s1_q, s1_d;
  logic [CNT_W-1:0] s2_q, s2_d;
  logic [1:0]       lock1_q, lock1_d;
  logic [1:0]       lock2_q, lock2_d;
  logic [1:0]       manche_q, manche_d;
  logic [1:0]       partita_q, partita_d;
  logic             ris_req_q, ris_req_d;
  logic [1:0]       ris_a_q, ris_a_d;
  logic [1:0]       ris_b_q, ris_b_d;

  logic             illegal;
  logic [1:0]       esito;
  logic [CNT_W-1:0] diff;

`ifdef MORRA_STATS_EN
  logic [CNT_W-1:0] partite_p1_q, partite_p1_d;
  logic [CNT_W-1:0] partite_p2_q, partite_p2_d;
`endif

  assign bus.MOSSA_PRONTA = (state_q == ATTESA);
  assign bus.RIS_REQ      = ris_req_q;
  assign bus.RIS_A        = ris_a_q;
  assign bus.RIS_B        = ris_b_q;
  assign bus.MANCHE       = manche_q;
  assign bus.PARTITA      = partita_q;

`ifdef MORRA_STATS_EN
  assign PARTITE_P1 = partite_p1_q;
  assign PARTITE_P2 = partite_p2_q;
`endif

  // Move legality, resolver result decode and absolute score difference.
  always_comb begin
    illegal = (bus.PRIMO == 2'b00) || (bus.SECONDO == 2'b00) ||
              (bus.PRIMO == lock1_q) || (bus.SECONDO == lock2_q);
    esito   = (bus.RIS_ESITO == 2'b00) ? 2'b11 : bus.RIS_ESITO;
    diff    = (s1_q >= s2_q) ? (s1_q - s2_q) : (s2_q - s1_q);
  end

  // Next-state and datapath update; INIZIA overrides everything.
  always_comb begin
    state_d      = state_q;
    max_manche_d = max_manche_q;
    rounds_d     = rounds_q;
    s1_d         = s1_q;
    s2_d         = s2_q;
    lock1_d      = lock1_q;
    lock2_d      = lock2_q;
    manche_d     = manche_q;
    partita_d    = partita_q;
    ris_req_d    = ris_req_q;
    ris_a_d      = ris_a_q;
    ris_b_d      = ris_b_q;

    if (bus.INIZIA) begin
      max_manche_d = CNT_W'(MIN_MANCHE) + CNT_W'({bus.PRIMO, bus.SECONDO});
      rounds_d     = '0;
      s1_d         = '0;
      s2_d         = '0;
      lock1_d      = '0;
      lock2_d      = '0;
      manche_d     = '0;
      partita_d    = '0;
      ris_req_d    = 1'b0;
      ris_a_d      = '0;
      ris_b_d      = '0;
      state_d      = ATTESA;
    end else begin
      case (state_q)
        ATTESA: begin
          if (bus.MOSSA_VALIDA) begin
            if (illegal) begin
              manche_d = '0;
            end else begin
              ris_a_d   = bus.PRIMO;
              ris_b_d   = bus.SECONDO;
              ris_req_d = 1'b1;
              state_d   = RISOLVI;
            end
          end
        end
        RISOLVI: begin
          if (bus.RIS_ACK && ris_req_q) begin
            ris_req_d = 1'b0;
            manche_d  = esito;
            if (rounds_q < max_manche_q) rounds_d = rounds_q + CNT_W'(1);
            case (esito)
              2'b01: begin
                s1_d    = s1_q + CNT_W'(1);
                lock1_d = ris_a_q;
                lock2_d = '0;
              end
              2'b10: begin
                s2_d    = s2_q + CNT_W'(1);
                lock1_d = '0;
                lock2_d = ris_b_q;
              end
              default: begin
                lock1_d = '0;
                lock2_d = '0;
              end
            endcase
            state_d = AGGIORNA;
          end
        end
        AGGIORNA: begin
          if ((rounds_q >= CNT_W'(MIN_MANCHE)) && (diff >= CNT_W'(LEAD))) begin
            partita_d = (s1_q > s2_q) ? 2'b01 : 2'b10;
            state_d   = FINE;
          end else if (rounds_q == max_manche_q) begin
            if (s1_q > s2_q)      partita_d = 2'b01;
            else if (s2_q > s1_q) partita_d = 2'b10;
            else                  partita_d = 2'b11;
            state_d = FINE;
          end else begin
            state_d = ATTESA;
          end
        end
        IDLE, FINE: ;
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef MORRA_STATS_EN
  // Saturating match-win counters, bumped on the AGGIORNA->FINE transition.
  always_comb begin
    partite_p1_d = partite_p1_q;
    partite_p2_d = partite_p2_q;
    if (state_q == AGGIORNA && state_d == FINE) begin
      if (partita_d == 2'b01 && partite_p1_q != '1) partite_p1_d = partite_p1_q + CNT_W'(1);
      if (partita_d == 2'b10 && partite_p2_q != '1) partite_p2_d = partite_p2_q + CNT_W'(1);
    end
  end

  // Statistics registers; cleared only by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      partite_p1_q <= '0;
      partite_p2_q <= '0;
    end else begin
      partite_p1_q <= partite_p1_d;
      partite_p2_q <= partite_p2_d;
    end
  end
`endif

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      max_manche_q <= '0;
      rounds_q     <= '0;
      s1_q         <= '0;
      s2_q         <= '0;
      lock1_q      <= '0;
      lock2_q      <= '0;
      manche_q     <= '0;
      partita_q    <= '0;
      ris_req_q    <= 1'b0;
      ris_a_q      <= '0;
      ris_b_q      <= '0;
    end else begin
      state_q      <= state_d;
      max_manche_q <= max_manche_d;
      rounds_q     <= rounds_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      lock1_q      <= lock1_d;
      lock2_q      <= lock2_d;
      manche_q     <= manche_d;
      partita_q    <= partita_d;
      ris_req_q    <= ris_req_d;
      ris_a_q      <= ris_a_d;
      ris_b_q      <= ris_b_d;
    end
  end

endmodule
